// File: rtl/data_memory_arbiter.sv
// Round-robin arbiter and sequencer that serialises two requesters onto one
// single-port data memory; every output is registered.
module data_memory_arbiter #(
    parameter int ADDR_WIDTH = 18,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  reset,

    input  logic                  m0_req,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_ack,
    output logic [DATA_WIDTH-1:0] m0_rdata,

    input  logic                  m1_req,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_ack,
    output logic [DATA_WIDTH-1:0] m1_rdata,

    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic [DATA_WIDTH-1:0] mem_rdata,

    output logic                  busy
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t                state, state_nxt;
    logic                  gnt, gnt_nxt;
    logic                  last_grant, last_grant_nxt;
    logic [ADDR_WIDTH-1:0] mem_addr_nxt;
    logic [DATA_WIDTH-1:0] mem_wdata_nxt;
    logic                  mem_read_nxt, mem_write_nxt;
    logic                  m0_ack_nxt, m1_ack_nxt;
    logic [DATA_WIDTH-1:0] m0_rdata_nxt, m1_rdata_nxt;
    logic                  busy_nxt;
    logic                  issue;
    logic                  issue_sel;

    always_comb begin
        // NOTE: every next value gets a default first, so no branch can infer a latch.
        state_nxt      = state;
        gnt_nxt        = gnt;
        last_grant_nxt = last_grant;
        mem_addr_nxt   = mem_addr;
        mem_wdata_nxt  = mem_wdata;
        mem_read_nxt   = 1'b0;
        mem_write_nxt  = 1'b0;
        m0_ack_nxt     = 1'b0;
        m1_ack_nxt     = 1'b0;
        m0_rdata_nxt   = m0_rdata;
        m1_rdata_nxt   = m1_rdata;
        issue          = 1'b0;
        issue_sel      = 1'b0;

        case (state)
            IDLE: begin
                if (m0_req || m1_req) begin
                    issue     = 1'b1;
                    issue_sel = (m0_req && m1_req) ? ~last_grant : m1_req;
                end
            end
            ACCESS: begin
                if (gnt) begin
                    m1_ack_nxt = 1'b1;
                    if (mem_read) m1_rdata_nxt = mem_rdata;
                end else begin
                    m0_ack_nxt = 1'b1;
                    if (mem_read) m0_rdata_nxt = mem_rdata;
                end
                last_grant_nxt = gnt;
                state_nxt      = DONE;
            end
            DONE: begin
                // Only the other side may be granted here; the served side's req is ignored.
                if (gnt ? m0_req : m1_req) begin
                    issue     = 1'b1;
                    issue_sel = ~gnt;
                end else begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase

        if (issue) begin
            state_nxt     = ACCESS;
            gnt_nxt       = issue_sel;
            mem_addr_nxt  = issue_sel ? m1_addr  : m0_addr;
            mem_wdata_nxt = issue_sel ? m1_wdata : m0_wdata;
            mem_read_nxt  = issue_sel ? ~m1_we   : ~m0_we;
            mem_write_nxt = issue_sel ? m1_we    : m0_we;
        end

        busy_nxt = (state_nxt != IDLE);
    end

    // NOTE: non-blocking assignments so every register samples pre-edge values.
    // Asynchronous reset drops mem_write at once, so no write can commit while reset is held.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            gnt        <= 1'b0;
            last_grant <= 1'b1;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            m0_ack     <= 1'b0;
            m1_ack     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            gnt        <= gnt_nxt;
            last_grant <= last_grant_nxt;
            mem_addr   <= mem_addr_nxt;
            mem_wdata  <= mem_wdata_nxt;
            mem_read   <= mem_read_nxt;
            mem_write  <= mem_write_nxt;
            m0_ack     <= m0_ack_nxt;
            m1_ack     <= m1_ack_nxt;
            m0_rdata   <= m0_rdata_nxt;
            m1_rdata   <= m1_rdata_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Self-checking bench: directed scenarios plus randomized traffic scored against
// a transaction-order memory model and fairness/latency bounds.
module tb_data_memory_arbiter;

    localparam int AW    = 18;
    localparam int DW    = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic [1:0]    req;
    logic [1:0]    we;
    logic [AW-1:0] addr  [2];
    logic [DW-1:0] wdata [2];
    logic          m0_ack, m1_ack;
    logic [DW-1:0] m0_rdata, m1_rdata;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata, mem_rdata;
    logic          mem_read, mem_write, busy;

    logic [1:0]    acks;
    logic [DW-1:0] rd [2];

    logic [DW-1:0] mem_arr [DEPTH];
    logic          bd_we;
    logic [3:0]    bd_addr;
    logic [DW-1:0] bd_data;

    logic [DW-1:0] ref_mem [DEPTH];
    logic [DW-1:0] last_rd [2];

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    data_memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk      (clk),
        .reset    (reset),
        .m0_req   (req[0]),
        .m0_we    (we[0]),
        .m0_addr  (addr[0]),
        .m0_wdata (wdata[0]),
        .m0_ack   (m0_ack),
        .m0_rdata (m0_rdata),
        .m1_req   (req[1]),
        .m1_we    (we[1]),
        .m1_addr  (addr[1]),
        .m1_wdata (wdata[1]),
        .m1_ack   (m1_ack),
        .m1_rdata (m1_rdata),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_read (mem_read),
        .mem_write(mem_write),
        .mem_rdata(mem_rdata),
        .busy     (busy)
    );

    assign acks  = {m1_ack, m0_ack};
    assign rd[0] = m0_rdata;
    assign rd[1] = m1_rdata;

    // Small memory standing in for data_memory_block, plus a backdoor load port.
    assign mem_rdata = (mem_addr < AW'(DEPTH)) ? mem_arr[mem_addr[3:0]] : 32'hDEAD_BEEF;

    always @(posedge clk) begin
        if (bd_we)
            mem_arr[bd_addr] <= bd_data;
        else if (mem_write && mem_addr < AW'(DEPTH))
            mem_arr[mem_addr[3:0]] <= mem_wdata;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req   = '0;
        we    = '0;
        repeat (2) @(negedge clk);
        reset      = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
    endtask

    // One uncontended transaction from IDLE with cycle-exact latency checks.
    task automatic single(input int k, input logic w, input logic [AW-1:0] a,
                          input logic [DW-1:0] d, input string tag);
        logic [DW-1:0] exp_rd;
        logic [1:0]    exp_ack;
        exp_rd   = w ? last_rd[k] : ref_mem[a[3:0]];
        exp_ack  = (k == 0) ? 2'b01 : 2'b10;
        req[k]   = 1'b1;
        we[k]    = w;
        addr[k]  = a;
        wdata[k] = d;
        @(negedge clk);
        check($sformatf("%s_access_rd", tag), mem_read, !w);
        check($sformatf("%s_access_wr", tag), mem_write, w);
        check($sformatf("%s_access_addr", tag), mem_addr, a);
        if (w) check($sformatf("%s_access_wdata", tag), mem_wdata, d);
        check($sformatf("%s_access_noack", tag), acks, 2'b00);
        @(negedge clk);
        check($sformatf("%s_ack", tag), acks, exp_ack);
        check($sformatf("%s_rdata", tag), rd[k], exp_rd);
        check($sformatf("%s_done_en", tag), {mem_read, mem_write}, 2'b00);
        if (w) ref_mem[a[3:0]] = d;
        else   last_rd[k] = exp_rd;
        req[k] = 1'b0;
        @(negedge clk);
        check($sformatf("%s_idle_ack", tag), acks, 2'b00);
        check($sformatf("%s_idle_busy", tag), busy, 1'b0);
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [1:0]    pending;
        logic          cur_we    [2];
        logic [3:0]    cur_addr  [2];
        logic [DW-1:0] cur_wdata [2];
        int            wait_cyc  [2];
        int            served    [2];
        logic [DW-1:0] old_val;

        reset    = 1'b1;
        req      = '0;
        we       = '0;
        addr[0]  = '0;
        addr[1]  = '0;
        wdata[0] = '0;
        wdata[1] = '0;
        bd_we    = 1'b0;
        bd_addr  = '0;
        bd_data  = '0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        repeat (2) @(negedge clk);

        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_mem_en", {mem_read, mem_write}, 2'b00);
        check("rst_acks", acks, 2'b00);
        check("rst_m0_rdata", m0_rdata, 0);
        check("rst_m1_rdata", m1_rdata, 0);
        check("rst_busy", busy, 1'b0);

        for (int i = 0; i < DEPTH; i++) begin
            ref_mem[i] = (i == 1) ? 32'h0000_00A5 : $urandom;
            bd_we   = 1'b1;
            bd_addr = 4'(i);
            bd_data = ref_mem[i];
            @(negedge clk);
        end
        bd_we = 1'b0;
        reset = 1'b0;
        @(negedge clk);

        // Reset then m0 read of the preloaded word.
        single(0, 1'b0, AW'(1), '0, "m0_read1");
        check("m0_read1_value", m0_rdata, 32'h0000_00A5);

        // m1 write then m0 read-back.
        single(1, 1'b1, AW'(0), 32'hFFFF_FFFF, "m1_write0");
        single(0, 1'b0, AW'(0), '0, "m0_read0");
        check("m0_read0_value", m0_rdata, 32'hFFFF_FFFF);

        // Contention straight after reset: m0 goes first.
        apply_reset();
        req     = 2'b11;
        we      = 2'b00;
        addr[0] = AW'(3);
        addr[1] = AW'(4);
        @(negedge clk);
        check("cont_m0_access", {mem_read, mem_addr}, {1'b1, AW'(3)});
        @(negedge clk);
        check("cont_m0_ack", acks, 2'b01);
        check("cont_m0_rdata", m0_rdata, ref_mem[3]);
        req[0] = 1'b0;
        @(negedge clk);
        check("cont_m1_access", {mem_read, mem_addr}, {1'b1, AW'(4)});
        check("cont_m1_noack", acks, 2'b00);
        @(negedge clk);
        check("cont_m1_ack", acks, 2'b10);
        check("cont_m1_rdata", m1_rdata, ref_mem[4]);
        req[1] = 1'b0;
        @(negedge clk);
        check("cont_idle", busy, 1'b0);

        // Round-robin with both requesters holding req.
        req     = 2'b11;
        we      = 2'b00;
        addr[0] = AW'(5);
        addr[1] = AW'(6);
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            check($sformatf("rr_ack_c%0d", c), acks,
                  (c % 4 == 2) ? 2'b01 : (c % 4 == 0) ? 2'b10 : 2'b00);
            if (c % 2 == 1)
                check($sformatf("rr_addr_c%0d", c), mem_addr, (c % 4 == 1) ? AW'(5) : AW'(6));
            if (c % 4 == 2) check($sformatf("rr_rd0_c%0d", c), m0_rdata, ref_mem[5]);
            if (c % 4 == 0) check($sformatf("rr_rd1_c%0d", c), m1_rdata, ref_mem[6]);
            if (c == 6) req[0] = 1'b0;
            if (c == 8) req[1] = 1'b0;
        end
        last_rd[0] = ref_mem[5];
        last_rd[1] = ref_mem[6];
        @(negedge clk);
        check("rr_idle", busy, 1'b0);

        // No requests: everything stays quiet and memory is untouched.
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("noop_c%0d", c), {mem_read, mem_write, busy}, 3'b000);
        end
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("noop_mem%0d", i), mem_arr[i], ref_mem[i]);

        // Reset asserted during the ACCESS cycle of a write.
        old_val  = ref_mem[2];
        req[0]   = 1'b1;
        we[0]    = 1'b1;
        addr[0]  = AW'(2);
        wdata[0] = 32'h1234_5678;
        @(negedge clk);
        check("rstw_access_wr", mem_write, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("rstw_wr_dropped", mem_write, 1'b0);
        check("rstw_busy_dropped", busy, 1'b0);
        req = '0;
        @(negedge clk);
        check("rstw_no_ack_in_reset", acks, 2'b00);
        reset      = 1'b0;
        last_rd[0] = '0;
        last_rd[1] = '0;
        @(negedge clk);
        check("rstw_mem_kept", mem_arr[2], old_val);
        check("rstw_no_ack", acks, 2'b00);
        check("rstw_idle", busy, 1'b0);
        single(0, 1'b0, AW'(2), '0, "rstw_reread");

        // Randomized traffic against the transaction-order memory model.
        pending = '0;
        for (int k = 0; k < 2; k++) begin
            wait_cyc[k] = 0;
            served[k]   = 0;
        end
        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(negedge clk);
            check("rnd_single_ack", acks, (acks == 2'b11) ? 2'b00 : acks);
            check("rnd_rw_excl", mem_read & mem_write, 1'b0);
            for (int k = 0; k < 2; k++) begin
                if (acks[k]) begin
                    check($sformatf("rnd_ack_expected%0d", k), pending[k], 1'b1);
                    if (pending[k]) begin
                        if (cur_we[k]) begin
                            check($sformatf("rnd_wr_hold%0d", k), rd[k], last_rd[k]);
                            ref_mem[cur_addr[k]] = cur_wdata[k];
                        end else begin
                            check($sformatf("rnd_rdata%0d", k), rd[k], ref_mem[cur_addr[k]]);
                            last_rd[k] = ref_mem[cur_addr[k]];
                        end
                        pending[k] = 1'b0;
                        if (pending[1-k]) served[1-k]++;
                    end
                end else begin
                    check($sformatf("rnd_rd_hold%0d", k), rd[k], last_rd[k]);
                end
            end
            for (int k = 0; k < 2; k++) begin
                if (pending[k]) begin
                    wait_cyc[k]++;
                    check($sformatf("rnd_starve%0d", k), served[k] <= 1, 1'b1);
                    check($sformatf("rnd_wait%0d", k), wait_cyc[k] <= 8, 1'b1);
                    if (wait_cyc[k] > 8) begin
                        pending[k] = 1'b0;
                        req[k]     = 1'b0;
                    end
                end else if ($urandom_range(0, 2) != 0) begin
                    pending[k]   = 1'b1;
                    cur_we[k]    = 1'($urandom_range(0, 1));
                    cur_addr[k]  = 4'($urandom_range(0, DEPTH - 1));
                    cur_wdata[k] = $urandom;
                    wait_cyc[k]  = 0;
                    served[k]    = 0;
                    req[k]       = 1'b1;
                    we[k]        = cur_we[k];
                    addr[k]      = AW'(cur_addr[k]);
                    wdata[k]     = cur_wdata[k];
                end else begin
                    req[k] = 1'b0;
                end
            end
        end

        // Drain outstanding requests, then compare the whole memory.
        req = '0;
        repeat (4) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (pending[k] && cur_we[k]) ref_mem[cur_addr[k]] = mem_arr[cur_addr[k]];
        end
        for (int i = 0; i < DEPTH; i++)
            check($sformatf("final_mem%0d", i), mem_arr[i], ref_mem[i]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
